// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

   localparam int unsigned MULT_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage : mult_pkg

// File: rtl/mult_datapath.sv
// Operand register, 2*WIDTH accumulator and carry-out adder for the shift-add multiplier.
// Optional macro MULT_HIGH_EN: registers the upper half of the product on prod_hi.
module mult_datapath
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi
);

   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next_c;
   logic [WIDTH:0]     sum_c;

   // Upper-half add with carry-out, then shift the whole accumulator right by one.
   always_comb begin
      sum_c      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      acc_next_c = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
      if (acc[0]) begin
         acc_next_c = {sum_c, acc[WIDTH-1:1]};
      end
   end

   // Multiplicand and accumulator: load captures operands, step iterates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand <= '0;
         acc   <= '0;
      end else if (load) begin
         mcand <= a;
         acc   <= {{WIDTH{1'b0}}, b};
      end else if (step) begin
         acc   <= acc_next_c;
      end
   end

   // Low half of the result, captured on the final iteration and held afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prod_lo <= '0;
      end else if (last) begin
         prod_lo <= acc_next_c[WIDTH-1:0];
      end
   end

`ifdef MULT_HIGH_EN
   // High half of the result, captured alongside the low half.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prod_hi <= '0;
      end else if (last) begin
         prod_hi <= acc_next_c[2*WIDTH-1:WIDTH];
      end
   end
`else
   assign prod_hi = '0;
`endif

endmodule : mult_datapath

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: controller FSM plus iteration counter, fixed WIDTH-cycle latency.
// Optional macro MULT_HIGH_EN: enables the upper product half on prod_hi (otherwise tied to 0).
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   mult_state_t   state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          busy_next, done_next;
   logic          load_c, step_c, last_c;

   // State, counter and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         busy  <= busy_next;
         done  <= done_next;
      end
   end

   // Next-state, counter and datapath control.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      load_c     = 1'b0;
      step_c     = 1'b0;
      last_c     = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (start) begin
               load_c     = 1'b1;
               state_next = RUN;
               cnt_next   = '0;
               busy_next  = 1'b1;
            end
         end
         RUN: begin
            step_c = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last_c     = 1'b1;
               state_next = DONE;
               cnt_next   = '0;
               done_next  = 1'b1;
            end else begin
               cnt_next  = cnt + CW'(1);
               busy_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   mult_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk     (clk),
      .reset   (reset),
      .load    (load_c),
      .step    (step_c),
      .last    (last_c),
      .a       (a),
      .b       (b),
      .prod_lo (prod_lo),
      .prod_hi (prod_hi)
   );

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed vectors, monitor pops expectations on done.
module tb_seq_multiplier;

   logic        clk;
   logic        reset;
   logic        start;
   logic [63:0] a, b;
   logic        busy, done;
   logic [63:0] prod_lo, prod_hi;

   typedef struct {
      logic [63:0] lo;
      logic [63:0] hi;
      int unsigned done_edge;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned edge_n = 0;
   logic        prev_done = 1'b0;

   seq_multiplier #(.WIDTH(64)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .prod_lo (prod_lo),
      .prod_hi (prod_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n++;

   function automatic logic [63:0] hi_sel(input logic [63:0] h);
`ifdef MULT_HIGH_EN
      return h;
`else
      return 64'd0;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Monitor: compare every done pulse against the scoreboard head.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (done) begin
            exp_t e;
            check("busy_with_done", 64'(busy), 64'd0);
            if (prev_done) check("done_width", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("prod_lo", prod_lo, e.lo);
               check("prod_hi", prod_hi, e.hi);
               check("done_edge", 64'(edge_n), 64'(e.done_edge));
            end
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // Present operands with start, wait for the accepting edge, then scramble inputs.
   task automatic issue(input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] lo, input logic [63:0] hi);
      exp_t e;
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~av; b = ~bv;
      e.lo = lo; e.hi = hi_sel(hi); e.done_edge = edge_n + 64;
      exp_q.push_back(e);
      check("busy_after_accept", 64'(busy), 64'd1);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_lo", prod_lo, 64'd0);
      check("rst_hi", prod_hi, 64'd0);
      reset = 1'b1;

      // First edge after release accepts; 3*5.
      issue(64'd3, 64'd5, 64'd15, 64'd0);
      wait_done();

      // Back-to-back from DONE: 2*7.
      issue(64'd2, 64'd7, 64'd14, 64'd0);
      wait_done();
      repeat (2) @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("hold_lo", prod_lo, 64'd14);

      // Zero-extended immediate.
      issue(64'h1000, 64'h0000_0000_0000_0FFF, 64'h0000_0000_00FF_F000, 64'd0);
      wait_done();

      // All ones squared.
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE);
      wait_done();

      // Carry into the high half only.
      issue(64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd2);
      wait_done();

      // Start re-pulsed during RUN is ignored.
      issue(64'hFFFF, 64'h1_0001, 64'h0000_0000_FFFF_FFFF, 64'd0);
      repeat (9) @(posedge clk);
      #1;
      a = 64'd7; b = 64'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_ignore_start", 64'(busy), 64'd1);
      wait_done();
      @(negedge clk);

      // Reset mid-RUN abandons the operation.
      issue(64'hDEAD, 64'hBEEF, 64'd0, 64'd0);
      repeat (29) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_lo", prod_lo, 64'd0);
      check("midrst_hi", prod_hi, 64'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      issue(64'd4, 64'd4, 64'd16, 64'd0);
      wait_done();

      repeat (4) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 64, which sets the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have port a, input, WIDTH bits: multiplicand (register-file operand).
REQ-006 SHALL have port b, input, WIDTH bits: multiplier (register operand or zero-extended immediate).
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port prod_lo, output, WIDTH bits: low half of the unsigned product a*b.
REQ-010 SHALL have port prod_hi, output, WIDTH bits: high half of the product (see Configuration).

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; start in DONE begins a new operation back-to-back.
REQ-013 SHALL capture a and b on the accepting edge; later changes to a and b SHALL have no effect on that operation.
REQ-014 SHALL ignore start while in RUN; the operation in progress continues unaffected.
REQ-015 SHALL perform one shift-add iteration per RUN cycle on a 2*WIDTH-bit accumulator: when the multiplier LSB is 1, add the multiplicand into the upper half with carry; then shift the accumulator right by 1.
REQ-016 SHALL use an iteration counter of clog2(WIDTH)+1 bits and SHALL leave RUN after exactly WIDTH iterations; there is no early termination.
REQ-017 SHALL give fixed latency: with start accepted at edge k, busy is high after edge k and done is high for exactly one cycle after edge k+WIDTH.
REQ-018 SHALL go from DONE to IDLE on the next edge when start is low.
REQ-019 SHALL make prod_lo/prod_hi valid when done is high and hold them until the next accepted start; during RUN they carry no meaning.
REQ-020 SHALL compute prod_lo = (a*b) mod 2^WIDTH, unsigned, with no overflow flag.
REQ-021 SHALL hold busy high in RUN only; done and busy SHALL never be high together.

Reset
REQ-022 SHALL, while reset is low, force the state to IDLE and the counter, accumulator, busy, done, prod_lo and prod_hi to 0, regardless of clk.
REQ-023 SHALL abandon an in-flight operation when reset is asserted mid-RUN, with no done pulse.
REQ-024 SHALL, after reset is released, accept start only at the first rising edge on which reset is high.

Configuration
REQ-025 SHALL honour macro MULT_HIGH_EN: when defined, prod_hi = floor(a*b / 2^WIDTH) (UMULH support).
REQ-026 SHALL, when MULT_HIGH_EN is undefined, drive prod_hi constant 0 and exclude the logic that registers the upper half of the result; the port list is unchanged.

Structure
REQ-027 SHALL take the FSM state typedef (mult_state_t) and the default width constant MULT_WIDTH=64 from shared package mult_pkg.
REQ-028 SHALL split into controller (FSM plus counter) in seq_multiplier and sub-module mult_datapath (operand registers, accumulator, adder with carry-out).

Verification
REQ-029 SHALL cover: a=3, b=5, start at edge k -> done one cycle after edge k+64; prod_lo=15; prod_hi=0.
REQ-030 SHALL cover: b=0x0000_0000_0000_0FFF (zero-extended imm 12'hFFF), a=0x1000 -> prod_lo=0xFF_F000; prod_hi=0.
REQ-031 SHALL cover: a=b=0xFFFF_FFFF_FFFF_FFFF -> prod_lo=0x1; prod_hi=0xFFFF_FFFF_FFFF_FFFE with MULT_HIGH_EN, 0 without it.
REQ-032 SHALL cover: start re-pulsed with new operands at RUN cycle 10 -> ignored; the original result appears at cycle 64.
REQ-033 SHALL cover: start held high in the DONE cycle with a=2, b=7 -> busy next cycle; done 64 cycles later with prod_lo=14.
REQ-034 SHALL cover: reset low at RUN cycle 30 -> immediately state IDLE and all outputs 0; no done pulse; a fresh a=4, b=4 after release -> prod_lo=16.
